ap_cycle_budget_ctrl: RTL and testbench
=======================================

# ap_cycle_budget_ctrl

Controller that sequences the approximate-region begin-cycle capture and enforces a cycle budget on each approximate region. It sits beside NextPC/Fetch: it decides when the begin-cycle register is loaded from the global cycle counter, tracks elapsed cycles, and raises a held force-exit request to the fetch/recovery logic when a programmable budget is exceeded.

## Interface
- Parameters:
  - `DATA_WIDTH`, 32, width of the cycle counter, begin-cycle, elapsed and budget values.
  - `FETCH_WIDTH`, 2, number of fetch-lane buffer-hit flags.
  - `INT_ISSUE_WIDTH`, 2, number of integer branch-result lanes.
  - `EXP_CNT_WIDTH`, 16, width of the expiration statistics counter.
- Ports:
  - `clk`, in, 1, clock. This is the only clock.
  - `rst`, in, 1, reset. Synchronous and active-high.
  - `cycleCounter`, in, DATA_WIDTH, free-running global cycle counter.
  - `bufferHit`, in, FETCH_WIDTH, per-lane fetch buffer hit.
  - `apBrValid`, in, INT_ISSUE_WIDTH, per-lane resolved branch is an approximate BCC.
  - `apBrBufHit`, in, INT_ISSUE_WIDTH, per-lane approximate branch that hit the buffer.
  - `flush`, in, 1, pipeline flush; aborts the current region.
  - `budgetWe`, in, 1, budget write enable.
  - `budgetIn`, in, DATA_WIDTH, new budget. A budget of 0 disables expiry.
  - `exitAck`, in, 1, consumer accepts the force-exit.
  - `beginCycle`, out, DATA_WIDTH, captured start cycle of the current region.
  - `elapsed`, out, DATA_WIDTH, cycles elapsed since `beginCycle`.
  - `regionActive`, out, 1, state is ACTIVE.
  - `forceExit`, out, 1, state is EXPIRED; held until acknowledged.
  - `expCount`, out, EXP_CNT_WIDTH, saturating count of expirations.

## Operation
- **Start event:**
  - `start` = OR over `bufferHit`, OR any lane `i` with `apBrValid[i] && !apBrBufHit[i]`.
- **Capture:**
  - `beginCycle <= cycleCounter` whenever `capture` is asserted. `capture` is defined per state below.
- **Elapsed:**
  - `elapsed = cycleCounter - beginCycle`, computed modulo 2^DATA_WIDTH, so counter wrap-around is handled.
- **Expiry condition:**
  - `expire = (budget != 0) && (elapsed >= budget)`, an unsigned compare.
- **Budget register:**
  - Reset value 0.
  - `budgetWe` loads `budgetIn`; the new value is used for the compare from the next cycle.
- **FSM states:** IDLE, ACTIVE, EXPIRED.
- **IDLE:**
  - `flush` → stay in IDLE.
  - `start` → go to ACTIVE with capture.
- **ACTIVE:**
  - Priority is `flush` > `expire` > `start`.
  - `flush` → IDLE.
  - `expire` → EXPIRED, with no capture, and `expCount` increments.
  - `start` → stay in ACTIVE and recapture (restart the region).
- **EXPIRED:**
  - `flush` → IDLE, counting as an implicit acknowledge.
  - `exitAck && start` → ACTIVE with capture.
  - `exitAck` alone → IDLE.
  - Otherwise stay in EXPIRED; `start` is ignored.
- **expCount:** saturates at all-ones.
- **Reset values:**
  - state = IDLE.
  - `beginCycle` = 0.
  - budget = 0.
  - `expCount` = 0.
  - `regionActive` = 0.
  - `forceExit` = 0.
  - `elapsed` = `cycleCounter` (since `beginCycle` is 0).

## Timing
- `start` at edge N → `beginCycle` and `regionActive` valid after edge N, i.e. in cycle N+1.
- `expire` is evaluated combinationally in cycle N from registered `beginCycle`/budget → `forceExit` = 1 from cycle N+1.
- `forceExit` is a level. It drops the cycle after `exitAck` or `flush` is sampled. `exitAck` while not EXPIRED is ignored.
- A `budgetWe` in the same cycle as an `expire` evaluation has no effect on that evaluation.
- `rst` mid-region returns the block to IDLE at the next edge, regardless of other inputs.

## Structure
- **Shared package (`FetchUnitTypes`):**
  - `ApBudgetState` enum (IDLE/ACTIVE/EXPIRED).
  - `AP_BUDGET_DISABLED` = 0 constant.
  - `ApExpCount` typedef.
- **Sub-module:** `ap_start_detect`, a combinational reduction of the lane flags to `start`. It is reusable by the begin-cycle capture logic.
- **Registers:**
  - Use the codebase `FlipFlopWE` for `beginCycle` and the budget.
  - The FSM and `expCount` are local `always_ff` blocks.

## Test plan
- **Reset, then start:** `rst` → all outputs 0. `bufferHit`=01 at `cycleCounter`=100 → `beginCycle`=100 and `regionActive`=1 next cycle; at counter 105, `elapsed`=5.
- **Expiry:** budget=10, start at 200 → `forceExit`=1 in the cycle after counter=210 is seen. It is held for 5 cycles until `exitAck`, then drops; `expCount`=1.
- **Wrap-around:** start at 0xFFFF_FFFC, budget=8 → `elapsed`=4 at counter 0x0000_0000, and expiry at counter 4.
- **Precedence:**
  - `flush`+`expire`+`start` in the same cycle → IDLE with no `expCount` increment.
  - `expire`+`start` → EXPIRED and `beginCycle` unchanged.
  - In EXPIRED, `exitAck`+`start` at 300 → ACTIVE with `beginCycle`=300.
- **Disabled budget and branch-lane filter:**
  - budget=0, active for 1000 cycles → never expires.
  - `apBrValid`=10 with `apBrBufHit`=10 → no start.
  - `apBrValid`=10 with `apBrBufHit`=00 → start.
- **Saturation and mid-region reset:**
  - Force expCount to all-ones (via 65535 expirations or a preloaded bench) → one more expiry leaves it at all-ones.
  - `rst` in ACTIVE → IDLE, `beginCycle`=0.

Source files
------------

// File: rtl/ap_cycle_budget_ctrl_pkg.sv
// Shared fetch-unit types for the approximate-region cycle budget controller.
package FetchUnitTypes;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    EXPIRED = 2'd2
  } ApBudgetState;

  // A budget of this value never expires a region.
  localparam int AP_BUDGET_DISABLED = 0;

  localparam int AP_EXP_CNT_WIDTH = 16;
  typedef logic [AP_EXP_CNT_WIDTH-1:0] ApExpCount;

endpackage

// File: rtl/FlipFlopWE.sv
// Register with synchronous active-high reset and write enable.
module FlipFlopWE #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over the write enable.
  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VALUE;
    else if (we) q <= d;
  end

endmodule

// File: rtl/ap_start_detect.sv
// Reduces fetch buffer hits and approximate-branch results to a region start.
module ap_start_detect #(
  parameter int FETCH_WIDTH     = 2,
  parameter int INT_ISSUE_WIDTH = 2
) (
  input  logic [FETCH_WIDTH-1:0]     bufferHit,
  input  logic [INT_ISSUE_WIDTH-1:0] apBrValid,
  input  logic [INT_ISSUE_WIDTH-1:0] apBrBufHit,
  output logic                       start
);

  // A resolved approximate branch only opens a region when it missed the buffer.
  always_comb begin
    start = (|bufferHit) | (|(apBrValid & ~apBrBufHit));
  end

endmodule

// File: rtl/ap_cycle_budget_ctrl.sv
// Sequences approximate-region begin-cycle capture and forces an exit when
// a region runs past its programmable cycle budget.
module ap_cycle_budget_ctrl
  import FetchUnitTypes::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int FETCH_WIDTH     = 2,
  parameter int INT_ISSUE_WIDTH = 2,
  parameter int EXP_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      cycleCounter,
  input  logic [FETCH_WIDTH-1:0]     bufferHit,
  input  logic [INT_ISSUE_WIDTH-1:0] apBrValid,
  input  logic [INT_ISSUE_WIDTH-1:0] apBrBufHit,
  input  logic                       flush,
  input  logic                       budgetWe,
  input  logic [DATA_WIDTH-1:0]      budgetIn,
  input  logic                       exitAck,
  output logic [DATA_WIDTH-1:0]      beginCycle,
  output logic [DATA_WIDTH-1:0]      elapsed,
  output logic                       regionActive,
  output logic                       forceExit,
  output logic [EXP_CNT_WIDTH-1:0]   expCount
);

  ApBudgetState             state_q, state_d;
  logic [EXP_CNT_WIDTH-1:0] exp_count_q, exp_count_d;
  logic [DATA_WIDTH-1:0]    begin_cycle_q;
  logic [DATA_WIDTH-1:0]    budget_q;
  logic                     start;
  logic                     capture;
  logic                     expire;
  logic                     exp_inc;

  ap_start_detect #(
    .FETCH_WIDTH    (FETCH_WIDTH),
    .INT_ISSUE_WIDTH(INT_ISSUE_WIDTH)
  ) u_start_detect (
    .bufferHit (bufferHit),
    .apBrValid (apBrValid),
    .apBrBufHit(apBrBufHit),
    .start     (start)
  );

  FlipFlopWE #(.WIDTH(DATA_WIDTH)) u_begin_cycle (
    .clk(clk), .rst(rst), .we(capture), .d(cycleCounter), .q(begin_cycle_q)
  );

  FlipFlopWE #(.WIDTH(DATA_WIDTH)) u_budget (
    .clk(clk), .rst(rst), .we(budgetWe), .d(budgetIn), .q(budget_q)
  );

  // Elapsed wraps modulo 2^DATA_WIDTH; expiry only sees the registered budget.
  always_comb begin
    elapsed = cycleCounter - begin_cycle_q;
    expire  = (budget_q != DATA_WIDTH'(AP_BUDGET_DISABLED)) && (elapsed >= budget_q);
  end

  // Next state, capture strobe and expiration count.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    exp_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && start) begin
          state_d = ACTIVE;
          capture = 1'b1;
        end
      end
      ACTIVE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (expire) begin
          state_d = EXPIRED;
          exp_inc = 1'b1;
        end else if (start) begin
          capture = 1'b1;
        end
      end
      EXPIRED: begin
        // Flush acts as an implicit acknowledge; start alone is ignored here.
        if (flush) begin
          state_d = IDLE;
        end else if (exitAck) begin
          if (start) begin
            state_d = ACTIVE;
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    exp_count_d = exp_count_q;
    if (exp_inc && (exp_count_q != {EXP_CNT_WIDTH{1'b1}}))
      exp_count_d = exp_count_q + EXP_CNT_WIDTH'(1);
  end

  // FSM and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_count_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_count_q <= exp_count_d;
    end
  end

  // Outputs are decoded straight from registered state.
  always_comb begin
    beginCycle   = begin_cycle_q;
    regionActive = (state_q == ACTIVE);
    forceExit    = (state_q == EXPIRED);
    expCount     = exp_count_q;
  end

endmodule

// File: tb/tb_ap_cycle_budget_ctrl.sv
// Directed bench for ap_cycle_budget_ctrl; a second narrow-counter instance
// shares the stimulus to reach expCount saturation quickly.
module tb_ap_cycle_budget_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cycleCounter;
  logic [1:0]  bufferHit, apBrValid, apBrBufHit;
  logic        flush, budgetWe, exitAck;
  logic [31:0] budgetIn;
  logic [31:0] beginCycle, elapsed;
  logic        regionActive, forceExit;
  logic [15:0] expCount;
  logic [31:0] s_beginCycle, s_elapsed;
  logic        s_regionActive, s_forceExit;
  logic [2:0]  s_expCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ap_cycle_budget_ctrl #(
    .DATA_WIDTH(32), .FETCH_WIDTH(2), .INT_ISSUE_WIDTH(2), .EXP_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .cycleCounter(cycleCounter), .bufferHit(bufferHit),
    .apBrValid(apBrValid), .apBrBufHit(apBrBufHit), .flush(flush),
    .budgetWe(budgetWe), .budgetIn(budgetIn), .exitAck(exitAck),
    .beginCycle(beginCycle), .elapsed(elapsed), .regionActive(regionActive),
    .forceExit(forceExit), .expCount(expCount)
  );

  ap_cycle_budget_ctrl #(
    .DATA_WIDTH(32), .FETCH_WIDTH(2), .INT_ISSUE_WIDTH(2), .EXP_CNT_WIDTH(3)
  ) dut_sat (
    .clk(clk), .rst(rst), .cycleCounter(cycleCounter), .bufferHit(bufferHit),
    .apBrValid(apBrValid), .apBrBufHit(apBrBufHit), .flush(flush),
    .budgetWe(budgetWe), .budgetIn(budgetIn), .exitAck(exitAck),
    .beginCycle(s_beginCycle), .elapsed(s_elapsed), .regionActive(s_regionActive),
    .forceExit(s_forceExit), .expCount(s_expCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_budget(input logic [31:0] b);
    budgetWe = 1'b1; budgetIn = b;
    tick();
    budgetWe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cycleCounter = 32'd50;
    bufferHit = 2'b00; apBrValid = 2'b00; apBrBufHit = 2'b00;
    flush = 1'b0; budgetWe = 1'b0; budgetIn = '0; exitAck = 1'b0;
    tick(); tick();
    total++; if (regionActive !== 1'b0) begin bad++; $display("FAIL reset_active got=%0d want=0", regionActive); end
    total++; if (forceExit !== 1'b0) begin bad++; $display("FAIL reset_force got=%0d want=0", forceExit); end
    total++; if (beginCycle !== 32'd0) begin bad++; $display("FAIL reset_begin got=%0d want=0", beginCycle); end
    total++; if (expCount !== 16'd0) begin bad++; $display("FAIL reset_expcnt got=%0d want=0", expCount); end
    total++; if (elapsed !== 32'd50) begin bad++; $display("FAIL reset_elapsed got=%0d want=50", elapsed); end
    rst = 1'b0;
  endtask

  task automatic test_start();
    cycleCounter = 32'd100; bufferHit = 2'b01;
    tick();
    bufferHit = 2'b00;
    total++; if (regionActive !== 1'b1) begin bad++; $display("FAIL start_active got=%0d want=1", regionActive); end
    total++; if (beginCycle !== 32'd100) begin bad++; $display("FAIL start_begin got=%0d want=100", beginCycle); end
    cycleCounter = 32'd105; exitAck = 1'b1;
    tick();
    exitAck = 1'b0;
    total++; if (elapsed !== 32'd5) begin bad++; $display("FAIL start_elapsed got=%0d want=5", elapsed); end
    total++; if (regionActive !== 1'b1) begin bad++; $display("FAIL ack_ignored_active got=%0d want=1", regionActive); end
    bufferHit = 2'b10;
    tick();
    bufferHit = 2'b00;
    total++; if (beginCycle !== 32'd105) begin bad++; $display("FAIL restart_begin got=%0d want=105", beginCycle); end
    cycleCounter = 32'd106; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (regionActive !== 1'b0) begin bad++; $display("FAIL flush_active got=%0d want=0", regionActive); end
  endtask

  task automatic test_expiry();
    write_budget(32'd10);
    cycleCounter = 32'd200; bufferHit = 2'b01;
    tick();
    bufferHit = 2'b00;
    for (int c = 201; c <= 210; c++) begin
      cycleCounter = 32'(c);
      total++; if (forceExit !== 1'b0) begin bad++; $display("FAIL early_expire at=%0d got=%0d want=0", c, forceExit); end
      tick();
    end
    total++; if (forceExit !== 1'b1) begin bad++; $display("FAIL expire_force got=%0d want=1", forceExit); end
    total++; if (expCount !== 16'd1) begin bad++; $display("FAIL expire_cnt got=%0d want=1", expCount); end
    for (int k = 0; k < 4; k++) begin
      cycleCounter = cycleCounter + 32'd1;
      bufferHit = (k == 1) ? 2'b01 : 2'b00;
      tick();
      total++; if (forceExit !== 1'b1) begin bad++; $display("FAIL hold_force k=%0d got=%0d want=1", k, forceExit); end
    end
    bufferHit = 2'b00;
    total++; if (beginCycle !== 32'd200) begin bad++; $display("FAIL hold_begin got=%0d want=200", beginCycle); end
    exitAck = 1'b1;
    tick();
    exitAck = 1'b0;
    total++; if (forceExit !== 1'b0 || regionActive !== 1'b0) begin bad++; $display("FAIL ack_drop got=%0d%0d want=00", forceExit, regionActive); end
    total++; if (expCount !== 16'd1) begin bad++; $display("FAIL ack_cnt got=%0d want=1", expCount); end
  endtask

  task automatic test_wrap();
    write_budget(32'd8);
    cycleCounter = 32'hFFFF_FFFC; bufferHit = 2'b01;
    tick();
    bufferHit = 2'b00;
    cycleCounter = 32'h0000_0000;
    #1;
    total++; if (elapsed !== 32'd4) begin bad++; $display("FAIL wrap_elapsed got=%0d want=4", elapsed); end
    for (int c = 0; c < 4; c++) begin
      cycleCounter = 32'(c);
      tick();
      total++; if (forceExit !== 1'b0) begin bad++; $display("FAIL wrap_early c=%0d got=%0d want=0", c, forceExit); end
    end
    cycleCounter = 32'd4;
    tick();
    total++; if (forceExit !== 1'b1) begin bad++; $display("FAIL wrap_expire got=%0d want=1", forceExit); end
    total++; if (expCount !== 16'd2) begin bad++; $display("FAIL wrap_cnt got=%0d want=2", expCount); end
    exitAck = 1'b1;
    tick();
    exitAck = 1'b0;
  endtask

  task automatic test_precedence();
    cycleCounter = 32'd1000; bufferHit = 2'b01;
    tick();
    cycleCounter = 32'd1008; flush = 1'b1;
    tick();
    flush = 1'b0; bufferHit = 2'b00;
    total++; if (regionActive !== 1'b0 || forceExit !== 1'b0) begin bad++; $display("FAIL flush_wins got=%0d%0d want=00", regionActive, forceExit); end
    total++; if (expCount !== 16'd2) begin bad++; $display("FAIL flush_cnt got=%0d want=2", expCount); end
    cycleCounter = 32'd2000; bufferHit = 2'b01;
    tick();
    cycleCounter = 32'd2008;
    tick();
    bufferHit = 2'b00;
    total++; if (forceExit !== 1'b1) begin bad++; $display("FAIL expire_over_start got=%0d want=1", forceExit); end
    total++; if (beginCycle !== 32'd2000) begin bad++; $display("FAIL expire_no_capture got=%0d want=2000", beginCycle); end
    total++; if (expCount !== 16'd3) begin bad++; $display("FAIL prec_cnt got=%0d want=3", expCount); end
    cycleCounter = 32'd300; exitAck = 1'b1; bufferHit = 2'b01;
    tick();
    exitAck = 1'b0; bufferHit = 2'b00;
    total++; if (regionActive !== 1'b1 || forceExit !== 1'b0) begin bad++; $display("FAIL ack_start got=%0d%0d want=10", regionActive, forceExit); end
    total++; if (beginCycle !== 32'd300) begin bad++; $display("FAIL ack_start_begin got=%0d want=300", beginCycle); end
    cycleCounter = 32'd301; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_disabled_filter();
    logic seen;
    write_budget(32'd0);
    cycleCounter = 32'd5000; apBrValid = 2'b10; apBrBufHit = 2'b10;
    tick();
    total++; if (regionActive !== 1'b0) begin bad++; $display("FAIL filter_hit got=%0d want=0", regionActive); end
    apBrBufHit = 2'b00;
    tick();
    apBrValid = 2'b00;
    total++; if (regionActive !== 1'b1 || beginCycle !== 32'd5000) begin bad++; $display("FAIL filter_miss got=%0d/%0d want=1/5000", regionActive, beginCycle); end
    seen = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      cycleCounter = 32'(5000 + i);
      tick();
      if (forceExit !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL disabled_expired got=%0d want=0", seen); end
    total++; if (elapsed !== 32'd1000) begin bad++; $display("FAIL disabled_elapsed got=%0d want=1000", elapsed); end
    budgetWe = 1'b1; budgetIn = 32'd5;
    tick();
    budgetWe = 1'b0;
    total++; if (forceExit !== 1'b0 || regionActive !== 1'b1) begin bad++; $display("FAIL we_same_cycle got=%0d%0d want=01", forceExit, regionActive); end
    cycleCounter = 32'd6001;
    tick();
    total++; if (forceExit !== 1'b1 || expCount !== 16'd4) begin bad++; $display("FAIL we_next_cycle got=%0d/%0d want=1/4", forceExit, expCount); end
    exitAck = 1'b1;
    tick();
    exitAck = 1'b0;
  endtask

  task automatic test_saturation();
    write_budget(32'd1);
    for (int k = 0; k < 5; k++) begin
      cycleCounter = 32'(7000 + 10 * k); bufferHit = 2'b01;
      tick();
      bufferHit = 2'b00; cycleCounter = cycleCounter + 32'd1;
      tick();
      exitAck = 1'b1;
      tick();
      exitAck = 1'b0;
      if (k == 2) begin
        total++; if (s_expCount !== 3'd7) begin bad++; $display("FAIL sat_reach got=%0d want=7", s_expCount); end
      end
    end
    total++; if (s_expCount !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d want=7", s_expCount); end
    total++; if (expCount !== 16'd9) begin bad++; $display("FAIL sat_main got=%0d want=9", expCount); end
  endtask

  task automatic test_mid_reset();
    cycleCounter = 32'd777; bufferHit = 2'b01;
    tick();
    total++; if (regionActive !== 1'b1) begin bad++; $display("FAIL mid_active got=%0d want=1", regionActive); end
    rst = 1'b1;
    tick();
    rst = 1'b0; bufferHit = 2'b00; cycleCounter = 32'd780;
    #1;
    total++; if (regionActive !== 1'b0 || forceExit !== 1'b0) begin bad++; $display("FAIL mid_rst_state got=%0d%0d want=00", regionActive, forceExit); end
    total++; if (beginCycle !== 32'd0) begin bad++; $display("FAIL mid_rst_begin got=%0d want=0", beginCycle); end
    total++; if (expCount !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", expCount); end
    total++; if (elapsed !== 32'd780) begin bad++; $display("FAIL mid_rst_elapsed got=%0d want=780", elapsed); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_expiry();
    test_wrap();
    test_precedence();
    test_disabled_filter();
    test_saturation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
